addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
Parametrised, multi-cycle, digit-serial two's-complement adder/subtractor with optional saturation and status flags. It processes CHUNK bits per cycle, least-significant chunk first, so the execute stage can trade latency for area on wide operands. It sits beside the single-cycle 16-bit add/sub in the ALU/EX datapath. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 16, operand and result width in bits; must be 2 or greater.
CHUNK, 4, bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK cycles per operation.
SAT_EN, 1, 1 = sat input honoured; 0 = sat ignored and treated as 0.

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
A  in  WIDTH  operand A, signed
B  in  WIDTH  operand B, signed
sub  in  1  0 = A+B, 1 = A-B
sat  in  1  1 = saturate on overflow
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
Sum  out  WIDTH  result, after saturation if enabled
Ovfl  out  1  raw signed overflow of the unsaturated result
Zero  out  1  Sum == 0 (post-saturation)
Neg  out  1  Sum[WIDTH-1] (post-saturation)

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset: state IDLE, count 0, Sum/Ovfl/Zero/Neg = 0, out_valid = 0, in_ready = 1. Reset wins over every other event, including mid-RUN and DONE; any operation in flight is discarded.
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - latch A into a_sh and (B ^ {WIDTH{sub}}) into b_sh;
  - set carry = sub; latch sat_q = sat & SAT_EN; latch a_sign = A[WIDTH-1] and b_sign = B[WIDTH-1] ^ sub;
  - set count = 0 and go to RUN.
- RUN: in_ready = 0; in_valid is ignored.
  - Each cycle, add the low CHUNK bits of a_sh and b_sh with carry.
  - Shift the chunk sum into the top of the result shift register, right-shift a_sh and b_sh by CHUNK, carry <= chunk carry-out, count++.
  - On the cycle count == N-1, also capture c_in_msb (carry into bit WIDTH-1) and c_out_msb, then go to DONE.
- Latency: result is registered and out_valid rises exactly N cycles after the accepting edge.
  - N = 1 (CHUNK == WIDTH) is legal and gives 1-cycle latency.
- Overflow: Ovfl = c_in_msb ^ c_out_msb, computed on the unsaturated sum. The carry out of bit WIDTH-1 is not reported.
- Saturation, applied when entering DONE if sat_q & Ovfl:
  - a_sign == 0 gives Sum = 0 followed by WIDTH-1 ones (max positive);
  - a_sign == 1 gives Sum = 1 followed by WIDTH-1 zeros (min negative).
  - Otherwise Sum is the wrapped result.
- Flags: Zero and Neg are computed from the final Sum and registered together with it.
- DONE: out_valid = 1, in_ready = 0. Sum/Ovfl/Zero/Neg are held stable while out_ready = 0. On out_ready, go to IDLE with out_valid = 0. The last result stays on Sum and the flags until the next DONE or reset.
- No overlap: a new operand is not accepted in the same cycle a result is consumed. Maximum throughput is one operation per N+2 cycles.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header addsub_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE (2 bits);
  - function clog2 for the count width (clog2(N), minimum 1);
  - sat_max/sat_min constant generation by WIDTH.
- One sub-module: addsub_chunk, a combinational CHUNK-bit ripple adder.
  - Inputs: a, b, cin. Outputs: s, cout, c_msb (carry into its top bit).
  - Built from the existing full_adder_1bit cells in a generate loop.
  - Instantiated once and reused every RUN cycle.

Test Plan:
- WIDTH=16, CHUNK=4: accept 0x1234 + 0x0FF0 (sub=0) -> after exactly 4 cycles out_valid=1, Sum=0x2224, Ovfl=0, Zero=0, Neg=0.
- 0x7FFF + 0x0001: with sat=0 -> Sum=0x8000, Ovfl=1, Neg=1; with sat=1 -> Sum=0x7FFF, Ovfl=1, Neg=0.
- 0x8000 - 0x0001: with sat=0 -> Sum=0x7FFF, Ovfl=1; with sat=1 -> Sum=0x8000, Ovfl=1, Neg=1. Also 0x0005 - 0x0005 -> Sum=0x0000, Zero=1, Ovfl=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> Sum and flags are stable and in_ready=0; in_valid pulsed during RUN is not accepted; after out_ready=1, in_ready=1 on the next cycle.
- Reset with rst_n=0 during RUN count 2 -> next edge gives IDLE, out_valid=0, in_ready=1, Sum=0. A following 0x0003 + 0xFFFF yields Sum=0x0002, Ovfl=0.
- Parameter sweep WIDTH=8, CHUNK=8 (N=1) and WIDTH=8, CHUNK=2 (N=4): 0x7F + 0x01 with sat=1 -> Sum=0x7F, Ovfl=1, with latency 1 and 4 respectively. Random self-check against a behavioural model across both configurations.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// count-width helper and saturation constant generation.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest operand the saturation helpers can describe.
    localparam int MAX_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return sat_min(w) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Ovfl;
    logic             Zero;
    logic             Neg;

    modport master (
        output in_valid, A, B, sub, sat, out_ready,
        input  in_ready, out_valid, Sum, Ovfl, Zero, Neg
    );

    modport slave (
        input  in_valid, A, B, sub, sat, out_ready,
        output in_ready, out_valid, Sum, Ovfl, Zero, Neg
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the final chunk.
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub: CHUNK bits per cycle, LS chunk first,
// optional saturation, registered result and flags behind valid/ready.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SAT_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    addsub_serial_if.slave bus
);
    localparam int               N       = WIDTH / CHUNK;
    localparam int               CW      = clog2(N);
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic             SAT_BIT = (SAT_EN != 0);
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             carry_q, sat_q, a_sign_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovfl_q, zero_q, neg_q, in_ready_q, out_valid_q;

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout, chunk_cmsb;
    logic [WIDTH-1:0] res_d, final_d;
    logic             ovfl_d;

    addsub_chunk #(.W(CHUNK)) u_chunk (
        .a     (a_sh_q[CHUNK-1:0]),
        .b     (b_sh_q[CHUNK-1:0]),
        .cin   (carry_q),
        .s     (chunk_s),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // Earlier chunks collect in a partial register; the current chunk lands on top.
    if (N == 1) begin : g_single
        assign res_d = chunk_s;
    end else begin : g_multi
        logic [WIDTH-CHUNK-1:0] part_q;
        always_ff @(posedge clk) begin
            if (state_q == ST_RUN) part_q <= res_d[WIDTH-1:CHUNK];
        end
        assign res_d = {chunk_s, part_q};
    end

    always_comb begin
        // NOTE: give every always_comb output a default first so no latch is inferred.
        final_d = res_d;
        ovfl_d  = chunk_cmsb ^ chunk_cout;
        if (sat_q && ovfl_d) final_d = a_sign_q ? SAT_MIN : SAT_MAX;
    end

    // NOTE: operand shift registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && bus.in_valid) begin
            a_sh_q   <= bus.A;
            b_sh_q   <= bus.B ^ {WIDTH{bus.sub}};
            carry_q  <= bus.sub;
            sat_q    <= bus.sat & SAT_BIT;
            a_sign_q <= bus.A[WIDTH-1];
        end else if (state_q == ST_RUN) begin
            a_sh_q  <= a_sh_q >> CHUNK;
            b_sh_q  <= b_sh_q >> CHUNK;
            carry_q <= chunk_cout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            sum_q       <= '0;
            ovfl_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        sum_q       <= final_d;
                        ovfl_q      <= ovfl_d;
                        zero_q      <= (final_d == '0);
                        neg_q       <= final_d[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Ovfl      = ovfl_q;
    assign bus.Zero      = zero_q;
    assign bus.Neg       = neg_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial in three configurations:
// 16/4 (N=4), 8/8 (N=1) and 8/2 (N=4), against an integer-arithmetic model.
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addsub_serial_if #(.WIDTH(16)) bus16 ();
    addsub_serial_if #(.WIDTH(8))  bus8a ();
    addsub_serial_if #(.WIDTH(8))  bus8b ();

    addsub_serial #(.WIDTH(16), .CHUNK(4), .SAT_EN(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    addsub_serial #(.WIDTH(8),  .CHUNK(8), .SAT_EN(1)) dut8a (.clk(clk), .rst_n(rst_n), .bus(bus8a.slave));
    addsub_serial #(.WIDTH(8),  .CHUNK(2), .SAT_EN(1)) dut8b (.clk(clk), .rst_n(rst_n), .bus(bus8b.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int cfg);
        return (cfg == 1) ? 1 : 4;
    endfunction

    task automatic set_in(input int cfg, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic st);
        case (cfg)
            0: begin bus16.in_valid = v; bus16.A = a;      bus16.B = b;      bus16.sub = s; bus16.sat = st; end
            1: begin bus8a.in_valid = v; bus8a.A = a[7:0]; bus8a.B = b[7:0]; bus8a.sub = s; bus8a.sat = st; end
            default: begin bus8b.in_valid = v; bus8b.A = a[7:0]; bus8b.B = b[7:0]; bus8b.sub = s; bus8b.sat = st; end
        endcase
    endtask

    task automatic get_out(input int cfg, output logic ir, output logic ov, output logic [15:0] sm,
                           output logic of, output logic z, output logic n);
        case (cfg)
            0: begin ir = bus16.in_ready; ov = bus16.out_valid; sm = bus16.Sum;
                     of = bus16.Ovfl; z = bus16.Zero; n = bus16.Neg; end
            1: begin ir = bus8a.in_ready; ov = bus8a.out_valid; sm = {8'h00, bus8a.Sum};
                     of = bus8a.Ovfl; z = bus8a.Zero; n = bus8a.Neg; end
            default: begin ir = bus8b.in_ready; ov = bus8b.out_valid; sm = {8'h00, bus8b.Sum};
                     of = bus8b.Ovfl; z = bus8b.Zero; n = bus8b.Neg; end
        endcase
    endtask

    // Reference: exact signed integer result, then range check and clamp or wrap.
    task automatic model(input int cfg, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic st, output logic [15:0] sm, output logic of,
                         output logic z, output logic n);
        int w, mask, hi, lo, av, bv, full, r;
        w    = (cfg == 0) ? 16 : 8;
        mask = (1 << w) - 1;
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        av   = int'(a) & mask;
        bv   = int'(b) & mask;
        if (av > hi) av -= (1 << w);
        if (bv > hi) bv -= (1 << w);
        full = s ? av - bv : av + bv;
        of   = (full > hi) || (full < lo);
        r    = full & mask;
        if (st && of) r = (full > hi) ? hi : (lo & mask);
        sm = 16'(r);
        z  = (r == 0);
        n  = ((r >> (w - 1)) & 1) == 1;
    endtask

    task automatic do_op(input int cfg, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic st, input string tag);
        logic [15:0] esm, sm;
        logic eof, ez, en, ir, ov, of, z, n;
        int lat;
        model(cfg, a, b, s, st, esm, eof, ez, en);
        get_out(cfg, ir, ov, sm, of, z, n);
        check({tag, " in_ready"}, 32'(ir), 32'd1);
        set_in(cfg, 1'b1, a, b, s, st);
        @(posedge clk); #1;
        set_in(cfg, 1'b0, a, b, s, st);
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            get_out(cfg, ir, ov, sm, of, z, n);
        end
        check({tag, " latency"}, 32'(lat), 32'(lat_of(cfg)));
        check({tag, " Sum"},  32'(sm), 32'(esm));
        check({tag, " Ovfl"}, 32'(of), 32'(eof));
        check({tag, " Zero"}, 32'(z),  32'(ez));
        check({tag, " Neg"},  32'(n),  32'(en));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] sm, hold;
        logic ir, ov, of, z, n;
        int lat;

        for (int c = 0; c < 3; c++) set_in(c, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        bus16.out_ready = 1'b1;
        bus8a.out_ready = 1'b1;
        bus8b.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            get_out(c, ir, ov, sm, of, z, n);
            check($sformatf("reset%0d in_ready", c), 32'(ir), 32'd1);
            check($sformatf("reset%0d out_valid", c), 32'(ov), 32'd0);
            check($sformatf("reset%0d Sum", c), 32'(sm), 32'd0);
            check($sformatf("reset%0d flags", c), {29'd0, of, z, n}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 16'h1234, 16'h0FF0, 1'b0, 1'b0, "add_basic");
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_wrap");
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, "pos_sat");
        do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, "neg_wrap");
        do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, "neg_sat");
        do_op(0, 16'h0005, 16'h0005, 1'b1, 1'b0, "sub_zero");

        // Backpressure: result held with out_ready low, in_valid during RUN ignored.
        bus16.out_ready = 1'b0;
        set_in(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b1, 16'h5555, 16'h5555, 1'b1, 1'b0);
        get_out(0, ir, ov, sm, of, z, n);
        check("bp run in_ready", 32'(ir), 32'd0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        lat = 2;
        get_out(0, ir, ov, sm, of, z, n);
        while (!ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            get_out(0, ir, ov, sm, of, z, n);
        end
        check("bp latency", 32'(lat), 32'd4);
        check("bp Sum", 32'(sm), 32'h3333);
        hold = sm;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            get_out(0, ir, ov, sm, of, z, n);
            check($sformatf("bp hold%0d Sum", k), 32'(sm), 32'(hold));
            check($sformatf("bp hold%0d valid/ready", k), {30'd0, ov, ir}, 32'b10);
            check($sformatf("bp hold%0d flags", k), {29'd0, of, z, n}, 32'd0);
        end
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        get_out(0, ir, ov, sm, of, z, n);
        check("bp release valid/ready", {30'd0, ov, ir}, 32'b01);
        check("bp release Sum kept", 32'(sm), 32'h3333);

        // Reset mid-RUN at count 2 discards the operation.
        set_in(0, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        get_out(0, ir, ov, sm, of, z, n);
        check("midrst valid/ready", {30'd0, ov, ir}, 32'b01);
        check("midrst Sum", 32'(sm), 32'd0);
        check("midrst Ovfl", 32'(of), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        get_out(0, ir, ov, sm, of, z, n);
        check("midrst discarded", {30'd0, ov, ir}, 32'b01);
        do_op(0, 16'h0003, 16'hFFFF, 1'b0, 1'b0, "post_rst");

        do_op(1, 16'h007F, 16'h0001, 1'b0, 1'b1, "w8c8_sat");
        do_op(2, 16'h007F, 16'h0001, 1'b0, 1'b1, "w8c2_sat");
        do_op(1, 16'h0080, 16'h0001, 1'b1, 1'b0, "w8c8_negwrap");
        do_op(2, 16'h0080, 16'h0001, 1'b1, 1'b1, "w8c2_negsat");

        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 30; i++) begin
                do_op(c, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                      $sformatf("rand%0d_%0d", c, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
